// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the EX-stage execute units: SELECT
//               opcode codes for the single-cycle ALU and the RV32M group,
//               the muldiv_unit FSM state encoding and the XLEN default.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int XLEN_DEF = 32;

    // SELECT[4:3] group code that routes an operation to muldiv_unit
    localparam logic [1:0] SEL_GRP_MULDIV = 2'b11;

    // A few single-cycle ALU codes (SELECT[4:3] != 2'b11)
    localparam logic [4:0] SEL_ALU_ADD = 5'b00000;
    localparam logic [4:0] SEL_ALU_SUB = 5'b00001;
    localparam logic [4:0] SEL_ALU_AND = 5'b00111;

    // RV32M funct3 codes carried in SELECT[2:0]
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

endpackage
`default_nettype wire

// File: rtl/cond_negate.sv
`default_nettype none
// ============================================================================
// Module      : cond_negate
// Description : W-bit conditional two's-complement. Used for operand
//               absolute values and for the result sign fix-up.
// Ports       : i_value [W-1:0] operand
//               i_neg           1 = output -i_value, 0 = pass through
//               o_value [W-1:0] result (modulo 2^W)
// Revision    : 1.0 - initial release
// ============================================================================
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_value,
    input  logic         i_neg,
    output logic [W-1:0] o_value
);

    assign o_value = i_neg ? (~i_value + W'(1)) : i_value;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multicycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/
//               DIVU/REM/REMU). Iterative radix-2 shift-add multiply and
//               restoring divide on magnitudes, followed by a one-cycle
//               sign fix-up. Divide-by-zero and signed overflow bypass the
//               iteration.
// Ports       : CLK     clock, rising edge
//               RESET   asynchronous, active-low reset
//               START   request, sampled on the rising edge
//               FLUSH   abort the in-flight operation
//               SELECT  {2'b11, funct3}
//               DATA1   rs1 operand (multiplicand / dividend)
//               DATA2   rs2 operand (multiplier / divisor)
//               RESULT  registered result, held until the next DONE
//               BUSY    operation in flight
//               DONE    one-cycle pulse, RESULT valid
// Config      : MULDIV_FAST_MUL_EN - when defined, multiplies use a single
//               combinational signed product and skip the iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            FLUSH,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic [XLEN-1:0] RESULT,
    output logic            BUSY,
    output logic            DONE
);

    localparam int            C_CW   = $clog2(XLEN);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(XLEN - 1);

    md_state_t         r_state;
    logic [2:0]        r_op;
    logic [C_CW-1:0]   r_cnt;
    // r_hi:r_lo is the 2*XLEN product accumulator for multiplies and
    // remainder:dividend/quotient for divides. r_b holds |multiplicand| or
    // |divisor|.
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_b;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;
    logic              r_done;

    // ------------------------------------------------------------------
    // Acceptance and operand decode
    // ------------------------------------------------------------------
    logic [2:0]        w_f3;
    logic              w_accept;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_div_ovf;

    assign w_f3     = SELECT[2:0];
    assign w_accept = (r_state == MD_IDLE) && START
                      && (SELECT[4:3] == SEL_GRP_MULDIV) && !FLUSH;
    assign w_is_div = w_f3[2];

    // MUL's low word is sign-independent, so it runs as unsigned.
    assign w_a_signed = (w_f3 == F3_MULH) || (w_f3 == F3_MULHSU)
                        || (w_f3 == F3_DIV) || (w_f3 == F3_REM);
    assign w_b_signed = (w_f3 == F3_MULH) || (w_f3 == F3_DIV)
                        || (w_f3 == F3_REM);
    assign w_a_neg    = w_a_signed && DATA1[XLEN-1];
    assign w_b_neg    = w_b_signed && DATA2[XLEN-1];

    assign w_div_zero = w_is_div && (DATA2 == '0);
    assign w_div_ovf  = ((w_f3 == F3_DIV) || (w_f3 == F3_REM))
                        && (DATA1 == {1'b1, {(XLEN-1){1'b0}}})
                        && (DATA2 == '1);

    cond_negate #(.W(XLEN)) u_abs_a (
        .i_value (DATA1),
        .i_neg   (w_a_neg),
        .o_value (w_a_abs)
    );

    cond_negate #(.W(XLEN)) u_abs_b (
        .i_value (DATA2),
        .i_neg   (w_b_neg),
        .o_value (w_b_abs)
    );

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to 2*XLEN makes the low 2*XLEN bits of an ordinary
    // product equal the signed/unsigned/mixed product required.
    logic [2*XLEN-1:0] w_fa;
    logic [2*XLEN-1:0] w_fb;
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_fa        = {{XLEN{w_a_neg}}, DATA1};
    assign w_fb        = {{XLEN{w_b_neg}}, DATA2};
    assign w_fast_prod = w_fa * w_fb;
`endif

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_add;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;

    assign w_add   = {1'b0, r_hi} + {1'b0, r_b};
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    // MSB set means borrow: the trial subtraction is discarded.
    assign w_diff  = w_shift - {1'b0, r_b};

    // ------------------------------------------------------------------
    // Sign fix-up and word select
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_result;

    // Low word of the negated accumulator doubles as the negated quotient.
    cond_negate #(.W(2*XLEN)) u_neg_prod (
        .i_value ({r_hi, r_lo}),
        .i_neg   (r_neg_res),
        .o_value (w_prod_fix)
    );

    cond_negate #(.W(XLEN)) u_neg_rem (
        .i_value (r_hi),
        .i_neg   (r_neg_rem),
        .o_value (w_rem_fix)
    );

    always_comb begin
        w_fix_result = w_prod_fix[XLEN-1:0];
        if (!r_op[2]) begin
            if (r_op[1:0] != 2'b00) begin
                w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
            end
        end else if (r_op[1]) begin
            w_fix_result = w_rem_fix;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= MD_IDLE;
            r_op      <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_f3;
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            // quotient all-ones, remainder = dividend
                            r_hi      <= DATA1;
                            r_lo      <= '1;
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                            r_state   <= MD_FIX;
                        end else if (w_div_ovf) begin
                            r_hi      <= '0;
                            r_lo      <= {1'b1, {(XLEN-1){1'b0}}};
                            r_neg_res <= 1'b0;
                            r_neg_rem <= 1'b0;
                            r_state   <= MD_FIX;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!w_is_div) begin
                            {r_hi, r_lo} <= w_fast_prod;
                            r_neg_res    <= 1'b0;
                            r_neg_rem    <= 1'b0;
                            r_state      <= MD_FIX;
`endif
                        end else begin
                            r_b       <= w_b_abs;
                            r_hi      <= '0;
                            r_lo      <= w_a_abs;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_state   <= MD_CALC;
                        end
                    end
                end

                MD_CALC: begin
                    if (FLUSH) begin
                        r_state <= MD_IDLE;
                    end else begin
                        if (!r_op[2]) begin
                            // multiplier bits consumed from r_lo[0]; the
                            // product shifts in from the top
                            if (r_lo[0]) begin
                                {r_hi, r_lo} <= {w_add, r_lo[XLEN-1:1]};
                            end else begin
                                {r_hi, r_lo} <= {1'b0, r_hi, r_lo[XLEN-1:1]};
                            end
                        end else begin
                            if (!w_diff[XLEN]) begin
                                r_hi <= w_diff[XLEN-1:0];
                                r_lo <= {r_lo[XLEN-2:0], 1'b1};
                            end else begin
                                r_hi <= w_shift[XLEN-1:0];
                                r_lo <= {r_lo[XLEN-2:0], 1'b0};
                            end
                        end
                        r_cnt <= r_cnt + C_CW'(1);
                        if (r_cnt == C_LAST) begin
                            r_state <= MD_FIX;
                        end
                    end
                end

                MD_FIX: begin
                    if (!FLUSH) begin
                        r_result <= w_fix_result;
                        r_done   <= 1'b1;
                    end
                    r_state <= MD_IDLE;
                end

                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign RESULT = r_result;
    assign BUSY   = (r_state != MD_IDLE);
    assign DONE   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. A transaction-level
//               model (plain 64-bit arithmetic plus a latency countdown)
//               predicts BUSY/DONE/RESULT every cycle; directed vectors
//               also carry hand-computed results and latencies.
// Config      : MULDIV_FAST_MUL_EN changes the expected multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam logic [4:0] C_MUL    = 5'b11000;
    localparam logic [4:0] C_MULH   = 5'b11001;
    localparam logic [4:0] C_MULHSU = 5'b11010;
    localparam logic [4:0] C_MULHU  = 5'b11011;
    localparam logic [4:0] C_DIV    = 5'b11100;
    localparam logic [4:0] C_DIVU   = 5'b11101;
    localparam logic [4:0] C_REM    = 5'b11110;
    localparam logic [4:0] C_REMU   = 5'b11111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int C_MUL_LAT = 1;
`else
    localparam int C_MUL_LAT = 33;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        FLUSH = 1'b0;
    logic [4:0]  SELECT = '0;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FLUSH  (FLUSH),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic (RISC-V M semantics) ----------
    function automatic logic [31:0] ref_result(input logic [4:0] sel,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, ub, r;
        longint unsigned uua, uub, ur;
        logic            ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'h0, b};
        uua = {32'h0, a};
        uub = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 0;
        ur  = 0;
        case (sel[2:0])
            3'd0: begin r = sa * sb; return r[31:0]; end
            3'd1: begin r = sa * sb; return r[63:32]; end
            3'd2: begin r = sa * ub; return r[63:32]; end
            3'd3: begin ur = uua * uub; return ur[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                r = sa / sb; return r[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                ur = uua / uub; return ur[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                r = sa % sb; return r[31:0];
            end
            default: begin
                if (b == 0) return a;
                ur = uua % uub; return ur[31:0];
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] sel,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        if (sel[2]) begin
            if (b == 0) return 1;
            if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return C_MUL_LAT;
    endfunction

    // ---------------- transaction model ---------------------------------
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend = '0;

    always @(negedge RESET) begin
        m_busy   = 1'b0;
        m_done   = 1'b0;
        m_result = '0;
    end

    always @(posedge CLK) begin
        if (RESET === 1'b1) begin
            m_done = 1'b0;
            if (m_busy) begin
                if (FLUSH) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy   = 1'b0;
                        m_done   = 1'b1;
                        m_result = m_pend;
                    end
                end
            end else if (START && SELECT[4:3] == 2'b11 && !FLUSH) begin
                m_busy = 1'b1;
                m_pend = ref_result(SELECT, DATA1, DATA2);
                m_left = ref_latency(SELECT, DATA1, DATA2);
            end
        end
    end

    // ---------------- per-cycle compare ---------------------------------
    always @(posedge CLK) begin
        #1;
        if (chk_en && RESET === 1'b1) begin
            chk("busy", {31'b0, BUSY}, {31'b0, m_busy});
            chk("done", {31'b0, DONE}, {31'b0, m_done});
            chk("result", RESULT, m_result);
        end
    end

    // ---------------- directed stimulus ---------------------------------
    task automatic wait_done(output int n);
        n = 0;
        while (DONE !== 1'b1 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    // Called at posedge+1; drives immediately so a call made in a DONE
    // cycle issues back-to-back.
    task automatic run_op(input string name, input logic [4:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        DATA1 = ~a; DATA2 = ~b;
        wait_done(n);
        chk({name, "_lat"}, n, lat);
        chk(name, RESULT, exp);
    endtask

    initial begin
        int n;
        int n_done;

        #12;
        chk("rst_result", RESULT, 32'h0);
        chk("rst_busy", {31'b0, BUSY}, 32'h0);
        chk("rst_done", {31'b0, DONE}, 32'h0);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        chk_en = 1'b1;

        // multiply family
        run_op("mul",    C_MUL,    32'd50000,     32'd200,       32'd10000000,  C_MUL_LAT);
        run_op("mulh",   C_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, C_MUL_LAT);
        run_op("mulhu",  C_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, C_MUL_LAT);
        run_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, C_MUL_LAT);
        run_op("mul_m1", C_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, C_MUL_LAT);

        // divide family, back-to-back
        run_op("div",  C_DIV,  32'hFFFF_FFE5, 32'd5, 32'hFFFF_FFFB, 33);
        run_op("rem",  C_REM,  32'hFFFF_FFE5, 32'd5, 32'hFFFF_FFFE, 33);
        run_op("divu", C_DIVU, 32'd27,        32'd5, 32'd5,         33);
        run_op("remu", C_REMU, 32'd27,        32'd5, 32'd2,         33);
        run_op("divu_big", C_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

        // special cases
        run_op("div_z",   C_DIV, 32'd10,        32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_z",   C_REM, 32'd10,        32'd0,         32'd10,        1);
        run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
        run_op("remu_z",  C_REMU, 32'd1234,     32'd0,         32'd1234,      1);

        // flush at iteration 10; RESULT keeps 1234
        SELECT = C_DIV; DATA1 = 32'd100; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) begin @(posedge CLK); #1; end
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        chk("flush_busy", {31'b0, BUSY}, 32'h0);
        chk("flush_done", {31'b0, DONE}, 32'h0);
        chk("flush_result", RESULT, 32'd1234);
        n_done = 0;
        repeat (40) begin @(posedge CLK); #1; if (DONE) n_done++; end
        chk("flush_no_done", n_done, 0);

        // START with FLUSH in idle, and a non-M SELECT: both ignored
        SELECT = C_DIVU; DATA1 = 32'd9; DATA2 = 32'd3; START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        chk("startflush_busy", {31'b0, BUSY}, 32'h0);
        SELECT = 5'b00000; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        chk("alusel_busy", {31'b0, BUSY}, 32'h0);

        // DIV 100/7 after the flush completes normally
        run_op("div_100_7", C_DIV, 32'd100, 32'd7, 32'd14, 33);

        // START while busy is ignored
        SELECT = C_DIVU; DATA1 = 32'd1000; DATA2 = 32'd7; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        SELECT = C_MUL; DATA1 = 32'd3; DATA2 = 32'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done(n);
        chk("busy_start_lat", n, 27);
        chk("busy_start_res", RESULT, 32'd142);
        @(posedge CLK); #1;
        chk("busy_start_idle", {31'b0, BUSY}, 32'h0);

        // asynchronous reset mid-CALC
        SELECT = C_MUL; DATA1 = 32'h1234; DATA2 = 32'h10; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        #2;
        RESET = 1'b0;
        #1;
        chk("arst_result", RESULT, 32'h0);
        chk("arst_busy", {31'b0, BUSY}, 32'h0);
        chk("arst_done", {31'b0, DONE}, 32'h0);
        @(negedge CLK); RESET = 1'b1;
        @(posedge CLK); #1;
        run_op("mul_6_7", C_MUL, 32'd6, 32'd7, 32'd42, C_MUL_LAT);

        repeat (3) @(posedge CLK);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
